fp_operand_unpack: RTL

FP_OPERAND_UNPACK -- requirements
Module: fp_operand_unpack

---
 rtl/fp_pkg.sv | 54 +++++
 rtl/fp_classify.sv | 25 ++
 rtl/fp_operand_unpack.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point operand types: class codes, unpacked-operand layouts and helpers.
// Used by the operand unpack stage and by the downstream special-case stage.
package fp_pkg;

    typedef enum logic [2:0] {
        FP_ZERO = 3'b000,
        FP_INF  = 3'b001,
        FP_SUB  = 3'b010,
        FP_NORM = 3'b011,
        FP_NAN  = 3'b100
    } fp_type_e;

    // Split IEEE-754 single fields plus class code (35 bits).
    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
        fp_type_e   cls;
    } fp_field_t;

    // Full 38-bit unpacked operand as consumed by the special-case stage.
    typedef struct packed {
        fp_field_t f;
        logic      hidden;
        logic      is_snan;
        logic      is_qnan;
    } fp_unpacked_t;

    typedef struct packed {
        fp_field_t a;
        fp_field_t b;
    } fp_pair_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Signalling NaN: NaN class with the quiet bit (frac MSB) clear.
    function automatic logic fp_is_snan(input fp_type_e cls, input logic [22:0] frac);
        return (cls == FP_NAN) && !frac[22];
    endfunction

    function automatic fp_unpacked_t fp_extend(input fp_field_t f);
        fp_unpacked_t u;
        u.f       = f;
        u.hidden  = (f.cls == FP_NORM);
        u.is_snan = fp_is_snan(f.cls, f.frac);
        u.is_qnan = (f.cls == FP_NAN) && f.frac[22];
        return u;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational split of a raw single-precision operand into sign/exponent/fraction and class code.
// Zero latency; no flow control.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] op,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [22:0] frac,
    output fp_type_e    cls
);

    always_comb begin
        sign = op[31];
        exp  = op[30:23];
        frac = op[22:0];
        cls  = FP_NORM;
        if (op[30:23] == 8'h00) begin
            cls = (op[22:0] == 23'd0) ? FP_ZERO : FP_SUB;
        end else if (op[30:23] == 8'hFF) begin
            cls = (op[22:0] == 23'd0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/fp_operand_unpack.sv
// Classifies operand pairs at acceptance into a 2-entry FIFO; output visible 1 cycle after accept.
// in_ready depends only on registered occupancy (low when full); outputs hold while out_ready is low.
module fp_operand_unpack
    import fp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        clr_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_A,
    output logic        sign_B,
    output logic [7:0]  exp_A,
    output logic [7:0]  exp_B,
    output logic [22:0] mantis_A,
    output logic [22:0] mantis_B,
    output logic [2:0]  type_A,
    output logic [2:0]  type_B,
    output logic        snan_seen,
    output logic [15:0] pair_count
);

    localparam int PTR_W = $clog2(DEPTH);

    fp_field_t  cls_a;
    fp_field_t  cls_b;
    fp_pair_t   mem [DEPTH];
    fp_pair_t   head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    occ_e       occ;
    occ_e       occ_nxt;
    logic       push;
    logic       pop;
    logic       snan_in;

    fp_classify u_cls_a (
        .op   (opa),
        .sign (cls_a.sign),
        .exp  (cls_a.exp),
        .frac (cls_a.frac),
        .cls  (cls_a.cls)
    );

    fp_classify u_cls_b (
        .op   (opb),
        .sign (cls_b.sign),
        .exp  (cls_b.exp),
        .frac (cls_b.frac),
        .cls  (cls_b.cls)
    );

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign snan_in = fp_is_snan(cls_a.cls, cls_a.frac) || fp_is_snan(cls_b.cls, cls_b.frac);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= OCC_EMPTY;
        end else begin
            occ <= occ_nxt;
        end
    end

    always_comb begin
        occ_nxt   = occ;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (push) occ_nxt = OCC_ONE;
            end
            OCC_ONE: begin
                out_valid = 1'b1;
                if (push && !pop)      occ_nxt = OCC_FULL;
                else if (pop && !push) occ_nxt = OCC_EMPTY;
            end
            OCC_FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (pop) occ_nxt = OCC_ONE;
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
    end

    // Entries reset to zero so the idle outputs are defined, not X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{a: cls_a, b: cls_b};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A new signalling NaN wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snan_seen  <= 1'b0;
            pair_count <= 16'd0;
        end else begin
            if (push && snan_in) begin
                snan_seen <= 1'b1;
            end else if (clr_flags) begin
                snan_seen <= 1'b0;
            end
            if (push && (pair_count != 16'hFFFF)) begin
                pair_count <= pair_count + 16'd1;
            end
        end
    end

    assign head     = mem[rd_ptr];
    assign sign_A   = head.a.sign;
    assign sign_B   = head.b.sign;
    assign exp_A    = head.a.exp;
    assign exp_B    = head.b.exp;
    assign mantis_A = head.a.frac;
    assign mantis_B = head.b.frac;
    assign type_A   = head.a.cls;
    assign type_B   = head.b.cls;

endmodule
